// File: rtl/als_sensor_emulator.sv
// SPI ambient-light sensor emulator (ADC081S021-style serial frame).
// SCK/CS are resynchronised to the system clock before any use.
module als_sensor_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic       i_system_clock,
  input  logic       i_aresetn,
  input  logic       i_sclk,
  input  logic       i_cs,
  input  logic [7:0] i_value,
  output logic       o_sdo,
  output logic       o_sdo_en,
  output logic       o_frame_done,
  output logic       o_frame_abort,
  output logic [7:0] o_frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT
  } state_t;

  localparam int         DONE_AT = FRAME_BITS - 1;
  localparam logic [4:0] CNT_MAX = 5'd16;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES:0]   warm_q, warm_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic [7:0]  count_q, count_d;

  logic        sclk_s, cs_s;
  logic        sclk_fall, cs_fall, cs_rise;
  logic        sync_ok;
  logic [2:0]  bit_idx;
  logic        in_data;

  // Synchroniser shift and edge-detect history; warm_q marks
  // when the CS chain holds real samples rather than reset values.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs};
    warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sync_ok   = warm_q[SYNC_STAGES];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  // Frame FSM: next state, bit counter, latch and frame pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (sync_ok && cs_s) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (cs_fall) begin
          state_d = SHIFT;
          shreg_d = i_value;
          cnt_d   = 5'd0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = ARMED;
          if (int'(cnt_q) >= DONE_AT) begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            abort_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_system_clock) begin
    if (!i_aresetn) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      warm_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      shreg_q     <= 8'h00;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      count_q     <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      warm_q      <= warm_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      count_q     <= count_d;
    end
  end

  // Serial data: three leading zeros, 8 data bits MSB first, then zeros.
  always_comb begin
    bit_idx  = 3'(5'd10 - cnt_q);
    in_data  = (cnt_q >= 5'd3) && (cnt_q <= 5'd10);
    o_sdo_en = (state_q == SHIFT);
    o_sdo    = 1'b0;
    if (o_sdo_en && in_data) begin
      o_sdo = shreg_q[bit_idx];
    end
  end

  assign o_frame_done  = done_q;
  assign o_frame_abort = abort_q;
  assign o_frame_count = count_q;

endmodule
